piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out framing serializer that sits directly downstream of the 4-bit PIPO register. It accepts a parallel word from the PIPO `q` output through a valid/ready handshake and shifts it out LSB-first on a single line. Each frame carries a start bit, the data bits, an optional parity bit and a stop bit, and every bit is held for a programmable number of clocks. It is the block that turns the PIPO's parallel output into a serial stream for the next link.

## Interface
Parameters:
- `WIDTH`, 4, data word width in bits (≥1); matches the PIPO width.
- `CLKS_PER_BIT`, 1, clock cycles each serial bit is held (≥1).
- `PARITY_EN`, 1, 1 inserts a parity bit after the data, 0 omits it.
- `PARITY_ODD`, 0, 0 selects even parity, 1 selects odd parity.

Ports (one clock; reset is synchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `rstn`  input  1  synchronous active-low reset.
- `d`  input  WIDTH  parallel word, driven from the PIPO `q`.
- `d_valid`  input  1  upstream has a word on `d`.
- `d_ready`  output  1  serializer can accept a word.
- `sout`  output  1  serial line; idles high.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse in the final clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when `PARITY_EN`=0.
- Handshake: a word is accepted on a rising edge where `d_valid`=1, `d_ready`=1 and `rstn`=1.
- `d_ready` = 1 only in IDLE with `rstn`=1; it is 0 in every other state.
- On accept, the word is captured into the shift register and the state moves to START.
  - The parity bit is computed from the captured word.
  - Later changes on `d` have no effect on the frame.
- Bit counter: a counter from 0 to `CLKS_PER_BIT`-1 times each bit. The state or bit advances when the counter reaches `CLKS_PER_BIT`-1.
- Serial line per state:
  - START: `sout`=0.
  - DATA: `sout` = shift-register LSB. The register shifts right once per bit. A bit index of $clog2(WIDTH) bits counts 0 to WIDTH-1, then the state moves to PARITY (or STOP).
  - PARITY: `sout` = XOR of the captured data for even parity, inverted XOR for odd parity.
  - STOP: `sout`=1. At the end of the stop bit the state returns to IDLE.
- `busy` = 1 in every state except IDLE.
- `done` = 1 in the last clock of STOP only.
- `sout`, `busy` and `done` are registered, or decoded from registered state with no combinational path from `d` or `d_valid`.
- Frame length: (WIDTH + PARITY_EN + 2) × CLKS_PER_BIT cycles.

## Timing
- Reset: on any edge with `rstn`=0, the block returns to IDLE regardless of the current state.
  - Outputs: `sout`=1, `busy`=0, `done`=0, `d_ready`=0 while `rstn`=0.
  - The shift register, bit counter and bit index clear to 0.
  - A frame interrupted mid-operation is abandoned; no partial stop bit and no `done`.
- Latency: `sout` goes low (start bit) in the cycle immediately after the accepting edge. `busy`=1 from that same cycle.
- `d_valid` with `d_ready`=0 is ignored. Upstream holds `d` and `d_valid`; the word is not queued.
- Back-to-back frames: after STOP, IDLE lasts at least one cycle with `d_ready`=1.
  - A word presented at that edge starts the next frame.
  - Minimum frame-to-frame period is frame length + 1 cycles.
- `d_valid`=1 during the `rstn` 0→1 edge is not accepted. The first accept is possible on the following edge.
- WIDTH=1: DATA lasts exactly one bit.
- CLKS_PER_BIT=1: each state lasts exactly one cycle.

## Test plan
All scenarios use defaults (WIDTH=4, CLKS_PER_BIT=1, even parity) unless noted.
- Reset: hold `rstn`=0 for 2 edges with `d_valid`=1 → `sout`=1, `busy`=0, `done`=0, `d_ready`=0; no frame starts.
- Single frame: `d`=4'b1010, `d_valid` for one accept → `sout` on successive cycles = 0,0,1,0,1,0,1; `busy`=1 for 7 cycles; `done` high only in cycle 7; `d_ready`=1 in cycle 8.
- Odd parity and capture: `PARITY_ODD`=1, `d`=4'b1011, then `d` changed to 4'b0000 one cycle after accept → `sout` = 0,1,1,0,1,0,1; the later change is ignored.
- Back-to-back with `d_valid` held high: words 4'b0010 then 4'b1111 → frames 0,0,1,0,0,1,1 then one idle cycle (`sout`=1), then 0,1,1,1,1,0,1. `d_ready` low throughout each frame.
- Stretched bits: `CLKS_PER_BIT`=3, `PARITY_EN`=0, `d`=4'b1110 → each of the bits 0,0,1,1,1,1 is held 3 cycles; frame is 18 cycles; `done` only in cycle 18.
- Reset mid-frame: `rstn`=0 for one edge during a DATA bit → next cycle IDLE with `sout`=1, `busy`=0 and no `done`. After `rstn`=1, `d_ready`=1 and a new word 4'b0001 transmits correctly as 0,1,0,0,0,1,1.

Source files
------------

// File: rtl/piso_serializer.sv
// Framing PISO serializer: start bit, LSB-first data, optional parity, stop bit,
// each bit held CLKS_PER_BIT clocks. Word accepted via valid/ready while idle.
module piso_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              bit_end;
    logic              line;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (d_valid) begin
                    shreg_d = d;
                    // Parity is taken from the captured word so later d changes cannot leak in
                    par_d   = (^d) ^ (PARITY_ODD != 0);
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        line = 1'b1;
        case (state_q)
            S_START:  line = 1'b0;
            S_DATA:   line = shreg_q[0];
            S_PARITY: line = par_q;
            default:  line = 1'b1;
        endcase
    end

    // Outputs are forced to their idle values while rstn is low, independent of state
    assign sout    = !rstn || line;
    assign busy    = rstn && (state_q != S_IDLE);
    assign done    = rstn && (state_q == S_STOP) && bit_end;
    assign d_ready = rstn && (state_q == S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances cover even parity,
// odd parity, and stretched bits without parity.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [3:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       s0, s1, s2;
    logic       b0, b1, b2;
    logic       dn0, dn1, dn2;

    piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rstn(rstn), .d(d0), .d_valid(v0), .d_ready(r0),
        .sout(s0), .busy(b0), .done(dn0));
    piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .clk(clk), .rstn(rstn), .d(d1), .d_valid(v1), .d_ready(r1),
        .sout(s1), .busy(b1), .done(dn1));
    piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
        .clk(clk), .rstn(rstn), .d(d2), .d_valid(v2), .d_ready(r2),
        .sout(s2), .busy(b2), .done(dn2));

    // expected {sout, busy, done, d_ready} per cycle
    typedef logic [3:0] exp_t;
    exp_t q0[$], q1[$], q2[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int which, input logic [3:0] w, input int pen,
                              input int podd, input int cpb);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 4; i++) bits.push_back(w[i]);
        if (pen != 0) bits.push_back((^w) ^ (podd != 0));
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cpb; c++) begin
                e = {bits[b], 1'b1, (b == bits.size() - 1) && (c == cpb - 1), 1'b0};
                if (which == 0) q0.push_back(e);
                else if (which == 1) q1.push_back(e);
                else q2.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = (q0.size() != 0) ? q0.pop_front() : {1'b1, 1'b0, 1'b0, rstn};
        chk("u0_even", {s0, b0, dn0, r0}, e);
        e = (q1.size() != 0) ? q1.pop_front() : {1'b1, 1'b0, 1'b0, rstn};
        chk("u1_odd", {s1, b1, dn1, r1}, e);
        e = (q2.size() != 0) ? q2.pop_front() : {1'b1, 1'b0, 1'b0, rstn};
        chk("u2_cpb3", {s2, b2, dn2, r2}, e);
    end

    initial begin
        // reset held two edges with valid high: nothing may start
        rstn = 1'b0;
        d0 = 4'hF; d1 = 4'hF; d2 = 4'hF;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        @(posedge clk); #1;

        // single frame, even parity
        d0 = 4'b1010; v0 = 1'b1;
        @(posedge clk); push_frame(0, 4'b1010, 1, 0, 1);
        #1 v0 = 1'b0; d0 = 4'b0000;
        repeat (9) @(posedge clk); #1;

        // odd parity; d changes right after capture
        d1 = 4'b1011; v1 = 1'b1;
        @(posedge clk); push_frame(1, 4'b1011, 1, 1, 1);
        #1 v1 = 1'b0; d1 = 4'b0000;
        repeat (9) @(posedge clk); #1;

        // back-to-back with valid held high
        d0 = 4'b0010; v0 = 1'b1;
        @(posedge clk); push_frame(0, 4'b0010, 1, 0, 1);
        #1 d0 = 4'b1111;
        repeat (7) @(posedge clk);
        @(posedge clk); push_frame(0, 4'b1111, 1, 0, 1);
        #1 v0 = 1'b0;
        repeat (9) @(posedge clk); #1;

        // stretched bits, no parity
        d2 = 4'b1110; v2 = 1'b1;
        @(posedge clk); push_frame(2, 4'b1110, 0, 0, 3);
        #1 v2 = 1'b0;
        repeat (20) @(posedge clk); #1;

        // reset in the middle of a DATA bit, then a clean frame
        d0 = 4'b0110; v0 = 1'b1;
        @(posedge clk); push_frame(0, 4'b0110, 1, 0, 1);
        #1 v0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0; q0.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        d0 = 4'b0001; v0 = 1'b1;
        @(posedge clk); push_frame(0, 4'b0001, 1, 0, 1);
        #1 v0 = 1'b0;
        repeat (10) @(posedge clk); #1;

        chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
